// File: rtl/add_sub_serial.sv
// -----------------------------------------------------------------------------
// add_sub_serial
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair is
// consumed DIGIT bits per clock through a DIGIT-bit ripple-carry slice, so one
// operation takes N = WIDTH/DIGIT cycles after the accepting edge.
//
// Ports
//   clk   in          rising-edge clock
//   rst   in          synchronous, active-high reset (priority over start)
//   start in          request, sampled only while busy = 0
//   sub   in          0: a + b, 1: a - b (sampled with start)
//   a, b  in  [WIDTH] operands (sampled with start)
//   busy  out         operation in progress
//   done  out         one-cycle completion pulse
//   res   out [WIDTH] result, held until the next completion
//   cout  out         final carry-out (for subtraction, 1 = no borrow)
//   ovf   out         signed overflow
// -----------------------------------------------------------------------------
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] sum_s;
  logic             cin_msb_s;
  logic             slice_cout_s;
  logic             last_s;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // DIGIT-bit ripple slice over the low digit of SA/SB; also exposes the carry
  // into its MSB, which on the final digit is the carry into bit WIDTH-1.
  always_comb begin
    logic c_v;
    c_v       = carry_q;
    sum_s     = '0;
    cin_msb_s = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      cin_msb_s          = c_v;
      {c_v, sum_s[i]}    = full_add(sa_q[i], sb_q[i], c_v);
    end
    slice_cout_s = c_v;
  end

  // Result shift register next value: new digit enters at the top.
  always_comb begin
    sr_d   = (sr_q >> DIGIT) | (WIDTH'(sum_s) << (WIDTH - DIGIT));
    last_s = (cnt_q == CW'(N - 1));
  end

  // Control FSM and all datapath/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B once here, seed carry with 1.
            sa_q    <= a;
            sb_q    <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q    <= sa_q >> DIGIT;
          sb_q    <= sb_q >> DIGIT;
          sr_q    <= sr_d;
          carry_q <= slice_cout_s;
          cnt_q   <= cnt_q + CW'(1);
          if (last_s) begin
            res_q   <= sr_d;
            cout_q  <= slice_cout_s;
            ovf_q   <= cin_msb_s ^ slice_cout_s;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
